// File: rtl/btn_debounce_pkg.sv
// Shared constants and types for the button conditioner, so that every top
// level agrees on tick rate, debounce depth and the board's polarity mask.
package btn_debounce_pkg;

   localparam int unsigned DEF_BITS           = 7;
   localparam int unsigned DEF_TICK_BITS      = 16;  // 2^16 clk @ 25 MHz ~ 2.6 ms
   localparam int unsigned DEF_STABLE_SAMPLES = 4;
   // btn[0] is the active-low PWR button on the ULX3S
   localparam logic [DEF_BITS-1:0] DEF_ACTIVE_LOW = 7'b0000001;

   // Per-channel conditioned outputs
   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } btn_ch_t;

   // Width of the agreement counter: must hold 0..stable_samples-1 without wrap
   function automatic int unsigned cnt_width(input int unsigned samples);
      return (samples < 2) ? 1 : $clog2(samples + 1);
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, polarity fix, tick-paced debounce,
// registered level and single-cycle rise/fall pulses.
module btn_debounce_ch
   import btn_debounce_pkg::*;
#(
   parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
   input  logic    clk_i,
   input  logic    resetn_i,
   input  logic    tick_i,
   input  logic    pin_i,
   input  logic    invert_i,
   output btn_ch_t out_o
);

   localparam int unsigned CNT_W = cnt_width(STABLE_SAMPLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

   logic [1:0]       sync_q;
   logic             s;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Bring the asynchronous pin into the clk domain
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) sync_q <= '0;
      else           sync_q <= {sync_q[0], pin_i};
   end

   // Pressed = 1 after polarity correction
   assign s = sync_q[1] ^ invert_i;

   // Debounce decision, evaluated only on a sample tick; pulses self-clear
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (tick_i) begin
         if (s == level_q) begin
            // any agreeing sample restarts the count (chatter rejection)
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            level_d = s;
            cnt_d   = '0;
            rise_d  = s;
            fall_d  = ~s;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Channel state and registered outputs
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         level_q <= 1'b0;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign out_o = '{level: level_q, rise: rise_q, fall: fall_q};

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button conditioner: one shared sample-tick divider feeding
// an array of independent debounce channels.
module btn_debounce
   import btn_debounce_pkg::*;
#(
   parameter int unsigned        BITS           = DEF_BITS,
   parameter int unsigned        TICK_BITS      = DEF_TICK_BITS,
   parameter int unsigned        STABLE_SAMPLES = DEF_STABLE_SAMPLES,
   parameter logic [BITS-1:0]    ACTIVE_LOW     = BITS'(DEF_ACTIVE_LOW)
) (
   input  logic            clk_i,
   input  logic            resetn_i,
   input  logic [BITS-1:0] btn_in_i,
   output logic [BITS-1:0] btn_level_o,
   output logic [BITS-1:0] btn_rise_o,
   output logic [BITS-1:0] btn_fall_o,
   output logic            tick_o
);

   logic [TICK_BITS-1:0] div_q;

   // Free-running divider; wraps naturally from all-ones to zero
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) div_q <= '0;
      else           div_q <= div_q + TICK_BITS'(1);
   end

   // Strobe is high for the single cycle the divider sits at all-ones
   assign tick_o = &div_q;

   for (genvar g = 0; g < BITS; g++) begin : g_ch
      btn_ch_t ch_out;

      btn_debounce_ch #(
         .STABLE_SAMPLES (STABLE_SAMPLES)
      ) u_ch (
         .clk_i    (clk_i),
         .resetn_i (resetn_i),
         .tick_i   (tick_o),
         .pin_i    (btn_in_i[g]),
         .invert_i (ACTIVE_LOW[g]),
         .out_o    (ch_out)
      );

      assign btn_level_o[g] = ch_out.level;
      assign btn_rise_o[g]  = ch_out.rise;
      assign btn_fall_o[g]  = ch_out.fall;
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: 16-clk tick, 4 stable samples, ULX3S polarity mask.
module tb_btn_debounce;

   localparam int unsigned BITS = 7;
   localparam logic [BITS-1:0] IDLE = 7'b0000001;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic [BITS-1:0] btn_in = IDLE;
   logic [BITS-1:0] btn_level, btn_rise, btn_fall;
   logic            tick;

   btn_debounce #(
      .BITS           (BITS),
      .TICK_BITS      (4),
      .STABLE_SAMPLES (4),
      .ACTIVE_LOW     (7'b0000001)
   ) dut (
      .clk_i       (clk),
      .resetn_i    (resetn),
      .btn_in_i    (btn_in),
      .btn_level_o (btn_level),
      .btn_rise_o  (btn_rise),
      .btn_fall_o  (btn_fall),
      .tick_o      (tick)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard entry: the pulse event expected after a stimulus step
   typedef struct {
      string           name;
      logic [BITS-1:0] rise;
      logic [BITS-1:0] fall;
      logic [BITS-1:0] level;
      int              t0;
      int              lmin;
      int              lmax;
   } exp_t;

   typedef struct {
      string           name;
      logic [BITS-1:0] btn;
      logic [BITS-1:0] rise;
      logic [BITS-1:0] fall;
      logic [BITS-1:0] level;
   } vec_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
      end
   endtask

   // Any pulse pops the oldest expectation; a pulse with nothing pending is an error
   always @(negedge clk) begin : mon
      exp_t e;
      if (mon_en && ((btn_rise | btn_fall) != '0)) begin
         if (q.size() == 0) begin
            chk("unexpected_pulse", {btn_rise, btn_fall}, 32'd0);
         end else begin
            e = q.pop_front();
            chk({e.name, "_rise"},  btn_rise,  e.rise);
            chk({e.name, "_fall"},  btn_fall,  e.fall);
            chk({e.name, "_level"}, btn_level, e.level);
            chk_rng({e.name, "_latency"}, cyc - e.t0, e.lmin, e.lmax);
         end
      end
   end

   task automatic expect_ev(input string nm, input logic [BITS-1:0] r, input logic [BITS-1:0] f,
                            input logic [BITS-1:0] l, input int lmin, input int lmax);
      q.push_back('{name: nm, rise: r, fall: f, level: l, t0: cyc, lmin: lmin, lmax: lmax});
   endtask

   // Wait (bounded) for all pending expectations, then let things settle
   task automatic wait_drain(input string nm);
      int n = 0;
      while (q.size() != 0 && n < 150) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk({nm, "_timeout"}, q.size(), 32'd0);
         q.delete();
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      btn_in = v.btn;
      expect_ev(v.name, v.rise, v.fall, v.level, 51, 67);
      wait_drain(v.name);
   endtask

   vec_t tbl[6];

   initial begin : main
      int c_rel, first, last, nt, per_bad, lvl_bad, n, k;

      tbl[0] = '{"press1",   7'b0000011, 7'b0000010, 7'b0000000, 7'b0000010};
      tbl[1] = '{"release1", 7'b0000001, 7'b0000000, 7'b0000010, 7'b0000000};
      tbl[2] = '{"pwr_on",   7'b0000000, 7'b0000001, 7'b0000000, 7'b0000001};
      tbl[3] = '{"pwr_off",  7'b0000001, 7'b0000000, 7'b0000001, 7'b0000000};
      tbl[4] = '{"all_on",   7'b1111110, 7'b1111111, 7'b0000000, 7'b1111111};
      tbl[5] = '{"all_off",  7'b0000001, 7'b0000000, 7'b1111111, 7'b0000000};

      // Reset and idle
      resetn = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset_outputs", {btn_level, btn_rise, btn_fall, tick}, 32'd0);
      resetn = 1'b1;
      c_rel  = cyc;
      mon_en = 1'b1;
      first = -1; last = 0; nt = 0; per_bad = 0; lvl_bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (btn_level != '0) lvl_bad++;
         if (tick) begin
            if (first < 0) first = cyc - c_rel;
            else if (cyc - last != 16) per_bad++;
            last = cyc;
            nt++;
         end
      end
      chk("idle_level", lvl_bad, 32'd0);
      chk_rng("first_tick", first, 15, 16);
      chk("tick_period", per_bad, 32'd0);
      chk("tick_count", nt, 32'd62);

      // Clean presses and active-low channel
      for (int i = 0; i < 4; i++) apply(tbl[i]);

      // Chatter on channel 2: 20-clk toggles never give 4 disagreeing ticks
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         btn_in[2] = (i % 2 == 0);
         repeat (19) @(negedge clk);
      end
      @(negedge clk);
      btn_in[2] = 1'b1;
      expect_ev("chatter_hold", 7'b0000100, 7'b0000000, 7'b0000100, 1, 67);
      wait_drain("chatter_hold");
      @(negedge clk);
      btn_in[2] = 1'b0;
      expect_ev("chatter_rel", 7'b0000000, 7'b0000100, 7'b0000000, 51, 67);
      wait_drain("chatter_rel");

      // Reset part-way through a debounce on channel 3
      @(negedge clk);
      btn_in = 7'b0001001;
      n = 0; k = 0;
      while (k < 2 && n < 100) begin
         @(negedge clk);
         n++;
         if (tick) k++;
      end
      chk("midrst_ticks", k, 32'd2);
      repeat (2) @(negedge clk);
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_in_reset", {btn_level[3], btn_rise, btn_fall}, 32'd0);
      resetn = 1'b1;
      expect_ev("midrst_press", 7'b0001000, 7'b0000000, 7'b0001000, 61, 67);
      wait_drain("midrst_press");
      @(negedge clk);
      btn_in = IDLE;
      expect_ev("midrst_rel", 7'b0000000, 7'b0001000, 7'b0000000, 51, 67);
      wait_drain("midrst_rel");

      // Simultaneous press / release of every channel
      for (int i = 4; i < 6; i++) apply(tbl[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      bad++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
